// File: rtl/debug_slave_pkg.sv
// Shared types for the Nios II debug slave command path: IR channel codes,
// the captured command record and a one-hot helper for the channel select.
package debug_slave_pkg;

    localparam int DEF_SR_W = 38;
    localparam int DEF_IR_W = 2;

    typedef enum logic [DEF_IR_W-1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } ir_code_e;

    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_SR_W-1:0] data;
    } cmd_t;

    function automatic logic [2**DEF_IR_W-1:0] onehot_ir(input logic [DEF_IR_W-1:0] ir);
        logic [2**DEF_IR_W-1:0] v;
        v     = '0;
        v[ir] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/debug_sync_edge.sv
// Synchroniser plus rising-edge detector for one virtual-JTAG strobe. The
// detector stays disarmed until the chain has settled after reset release.
module debug_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic                   w_armed;

    // By the time this is set, r_sync_d already reflects a strobe held
    // high across reset, so such a level never reads as an edge.
    assign w_armed = (r_arm_cnt == ARM_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= '0;
            r_sync_d  <= 1'b0;
            r_arm_cnt <= '0;
            o_rise    <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_sync_d <= r_sync[SYNC_STAGES-1];
            if (!w_armed)
                r_arm_cnt <= r_arm_cnt + 1'b1;
            o_rise <= w_armed & r_sync[SYNC_STAGES-1] & ~r_sync_d;
        end
    end

endmodule

// File: rtl/nios2_debug_slave_cmd_sync.sv
// System-clock side of the debug slave: synchronises the JTAG update strobes
// and queues each update-DR as a command for the CPU debug logic.
module nios2_debug_slave_cmd_sync
    import debug_slave_pkg::*;
#(
    parameter int SR_W        = DEF_SR_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vs_uir,
    input  logic                          vs_udr,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [SR_W-1:0]               sr,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [SR_W-1:0]               cmd_data,
    output logic [2**IR_W-1:0]            cmd_sel,
    output logic                          ir_update,
    output logic [IR_W-1:0]               ir_cur,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              drop_cnt,
    input  logic                          ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [IR_W-1:0] r_ir_mem   [FIFO_DEPTH];
    logic [SR_W-1:0] r_data_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;

    logic w_uir_rise, w_udr_rise;
    logic w_empty, w_full, w_pop, w_push, w_drop;

    debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk(clk), .reset_n(reset_n), .i_async(vs_uir), .o_rise(w_uir_rise)
    );

    debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk(clk), .reset_n(reset_n), .i_async(vs_udr), .o_rise(w_udr_rise)
    );

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = cmd_valid & cmd_ready;
    // When full, a same-cycle pop frees the slot being written.
    assign w_push  = w_udr_rise & (~w_full | w_pop);
    assign w_drop  = w_udr_rise & ~w_push;

    assign cmd_valid  = ~w_empty;
    assign cmd_ir     = r_ir_mem[r_rd_ptr[AW-1:0]];
    assign cmd_data   = r_data_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level = r_wr_ptr - r_rd_ptr;

    always_comb begin
        cmd_sel = '0;
        if (cmd_valid)
            cmd_sel[cmd_ir] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_ir_mem[i]   <= '0;
                r_data_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            ir_update <= 1'b0;
            ir_cur    <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            ir_update <= w_uir_rise;
            if (w_uir_rise)
                ir_cur <= ir_in;
            if (w_push) begin
                r_ir_mem[r_wr_ptr[AW-1:0]]   <= ir_in;
                r_data_mem[r_wr_ptr[AW-1:0]] <= sr;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            // A drop outranks a coincident clear.
            if (w_drop) begin
                overflow <= 1'b1;
                if (ovf_clr)
                    drop_cnt <= CNT_W'(1);
                else if (~&drop_cnt)
                    drop_cnt <= drop_cnt + 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule
